// File: rtl/digit_serial_pkg.sv
// Shared definitions for the digit-serial add/sub block: FSM state encoding,
// a constant ceil-log2 for sizing the digit counter, and a helper used by the
// top level to reject configurations where D does not divide N.
package digit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit divides_evenly(input int n, input int d);
    return (d > 0) && ((n % d) == 0);
  endfunction

endpackage

// File: rtl/Full_Adder.sv
// One-bit full adder cell, the building block of the digit adder.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/digit_adder.sv
// Combinational D-bit ripple-carry adder; one instance is reused every digit
// cycle by the serial add/sub.
module digit_adder #(
  parameter int D = 8
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout
);

  // carry[i] is the carry into bit i; carry[D] leaves the digit.
  logic [D:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[D];

  for (genvar i = 0; i < D; i++) begin : g_bit
    Full_Adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/digit_serial_add_sub.sv
// Digit-serial signed adder/subtractor: S = A + B (k=0) or A - B (k=1) on
// N-bit two's-complement operands, D bits per clock, N+1-bit sign-extended
// result plus signed-overflow flag.
// Optional feature macro: DIGIT_SERIAL_ADD_SUB_SAT_EN adds a saturated
// N-bit result port s_sat.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; while
// out_valid is high and out_ready is low, s/ovf (and s_sat) hold steady.
module digit_serial_add_sub
  import digit_serial_pkg::*;
#(
  parameter int N = 32,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   s,
`ifdef DIGIT_SERIAL_ADD_SUB_SAT_EN
  output logic [N-1:0] s_sat,
`endif
  output logic         ovf
);

  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  if (!divides_evenly(N, D) || N < 2) begin : g_cfg_err
    $error("digit_serial_add_sub: N must be >= 2 and divisible by D");
  end

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  xb_q, xb_d;      // b, or ~b for subtraction
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N:0]    s_q, s_d;
  logic          ovf_q, ovf_d;
`ifdef DIGIT_SERIAL_ADD_SUB_SAT_EN
  logic [N-1:0]  sat_q, sat_d;
`endif

  logic [31:0]   dig_base;
  logic [D-1:0]  dig_a, dig_b, dig_sum;
  logic          dig_cout;

  // Select the current digit of both operands for the shared adder.
  always_comb begin
    dig_base = 32'(cnt_q) * 32'(D);
    dig_a    = a_q[dig_base +: D];
    dig_b    = xb_q[dig_base +: D];
  end

  digit_adder #(.D(D)) u_digit_adder (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    xb_d    = xb_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
`ifdef DIGIT_SERIAL_ADD_SUB_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          xb_d    = k ? ~b : b;
          carry_d = k;            // +1 completes the two's-complement negate
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[dig_base +: D] = dig_sum;
        carry_d = dig_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_DIG) begin
          // Sign extension: sum bit N of the operands sign-extended by one.
          s_d[N]  = dig_a[D-1] ^ dig_b[D-1] ^ dig_cout;
          ovf_d   = s_d[N] ^ s_d[N-1];
`ifdef DIGIT_SERIAL_ADD_SUB_SAT_EN
          if (!ovf_d)      sat_d = s_d[N-1:0];
          else if (s_d[N]) sat_d = {1'b1, {(N-1){1'b0}}};
          else             sat_d = {1'b0, {(N-1){1'b1}}};
`endif
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      xb_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
`ifdef DIGIT_SERIAL_ADD_SUB_SAT_EN
      sat_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      xb_q    <= xb_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
`ifdef DIGIT_SERIAL_ADD_SUB_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign ovf       = ovf_q;
`ifdef DIGIT_SERIAL_ADD_SUB_SAT_EN
  assign s_sat     = sat_q;
`endif

endmodule
